fetch_stage: RTL

Instruction-fetch stage of the 16-bit pipelined core. It owns the PC register and drives the instruction-memory/I-cache request, tolerating multi-cycle misses. It latches the IF/ID pipeline register and presents the current PC to the PC-control logic, which returns the next PC (PC+2 or the branch target). It also handles pipeline flush on taken branches, hazard stalls, and HLT detection.

---
 rtl/fetch_stage.sv | 91 +++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, imem request, IF/ID latch, flush/stall/halt
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc_next,
    input  logic        branch_taken,
    input  logic        hazard_stall,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    output logic [15:0] pc_cur,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic        ifid_valid,
    output logic        fetch_stall,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_MISS  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ifid_instr;
    logic [15:0] r_ifid_pc;
    logic        r_ifid_valid;

    logic        w_req;
    logic        w_accept;
    logic        w_is_hlt;

    // Request is masked by reset combinationally so nothing is issued while rst_n is low.
    assign w_req    = rst_n & (r_state != S_HALT);
    assign w_accept = w_req & imem_rdy & ~branch_taken & ~hazard_stall;
    assign w_is_hlt = (imem_data[15:12] == HLT_OPCODE);

    assign imem_addr   = r_pc;
    assign imem_req    = w_req;
    assign pc_cur      = r_pc;
    assign ifid_instr  = r_ifid_instr;
    assign ifid_pc     = r_ifid_pc;
    assign ifid_valid  = r_ifid_valid;
    assign fetch_stall = w_req & ~imem_rdy;
    assign halted      = rst_n & (r_state == S_HALT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_ifid_instr <= 16'h0000;
            r_ifid_pc    <= 16'h0000;
            r_ifid_valid <= 1'b0;
        end else if (branch_taken) begin
            // Redirect discards whatever the memory returns for the old PC.
            r_state      <= S_FETCH;
            r_pc         <= pc_next;
            r_ifid_instr <= 16'h0000;
            r_ifid_pc    <= 16'h0000;
            r_ifid_valid <= 1'b0;
        end else if (hazard_stall) begin
            r_state      <= r_state;
        end else if (w_accept) begin
            r_ifid_instr <= imem_data;
            r_ifid_pc    <= r_pc;
            r_ifid_valid <= 1'b1;
            if (w_is_hlt) begin
                r_state <= S_HALT;
            end else begin
                r_state <= S_FETCH;
                r_pc    <= pc_next;
            end
        end else if (r_state == S_HALT) begin
            r_ifid_instr <= 16'h0000;
            r_ifid_pc    <= 16'h0000;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state      <= S_MISS;
            r_ifid_instr <= 16'h0000;
            r_ifid_pc    <= 16'h0000;
            r_ifid_valid <= 1'b0;
        end
    end

endmodule
